// File: rtl/offnariscv_pkg.sv
// offnariscv_pkg: shared types for the dispatch stage (operand beats, lane
// beats, writeback beats, forwarding selectors, credit counter width).
package offnariscv_pkg;
  localparam int XLEN      = 32;
  localparam int CMD_W     = 8;
  localparam int MAX_FU    = 8;
  localparam int MAX_FWD   = 4;
  localparam int FWD_SEL_W = $clog2(MAX_FWD + 1);
  localparam int CREDIT_W  = 4;

  // 0 selects the register-file operand, k selects forwarding source k-1
  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  typedef struct packed {
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [CMD_W-1:0] cmd;
  } lane_tdata_t;

  // Lanes above NUM_FU in fu_vld are ignored by the dispatcher
  typedef struct packed {
    logic [MAX_FU-1:0] fu_vld;
    fwd_sel_t          sel1;
    fwd_sel_t          sel2;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [CMD_W-1:0]  cmd;
  } dispatch_tdata_t;

  typedef struct packed {
    logic [MAX_FU-1:0] fu_vld;
    lane_tdata_t       lane;
  } exwb_tdata_t;

  typedef enum logic {LANE_EMPTY, LANE_FULL} lane_state_e;
endpackage

// File: rtl/axis_if.sv
// axis_if: minimal AXI-stream handshake bundle, width set per instance.
interface axis_if #(parameter int W = 32);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock stream FIFO with synchronous flush.
// s_tready reflects occupancy only (no same-cycle pop-through when full).
module axis_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  assign s_tready = count != (PW+1)'(DEPTH);
  assign m_tvalid = count != '0;
  assign m_tdata  = mem[rd_ptr];
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  // Pointer and occupancy bookkeeping; flush discards everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; validity comes from count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end
endmodule

// File: rtl/dispatch_lane.sv
// dispatch_lane: one issue lane -- output slot, EMPTY/FULL state and the
// credit counter bounding beats outstanding in the functional unit.
module dispatch_lane
  import offnariscv_pkg::*;
#(
  parameter int CREDITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        invalidate,
  input  logic        load,
  input  lane_tdata_t load_data,
  input  logic        done,
  input  logic        tready,
  output logic        tvalid,
  output lane_tdata_t tdata,
  output logic        slot_free,
  output logic        has_credit
);
  localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(CREDITS);

  lane_state_e         state;
  logic [CREDIT_W-1:0] credit;

  assign slot_free  = !tvalid || tready;
  assign has_credit = credit != '0;

  // Slot FSM; a handshake together with a reload keeps the slot FULL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= LANE_EMPTY;
      tvalid <= 1'b0;
    end else if (invalidate) begin
      state  <= LANE_EMPTY;
      tvalid <= 1'b0;
    end else begin
      case (state)
        LANE_EMPTY: if (load) begin
          state  <= LANE_FULL;
          tvalid <= 1'b1;
        end
        LANE_FULL: if (tready && !load) begin
          state  <= LANE_EMPTY;
          tvalid <= 1'b0;
        end
      endcase
    end
  end

  // Payload only changes on load, so it holds steady while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tdata <= '0;
    else if (load) tdata <= load_data;
  end

  // Credits: spend on load, return on done, cancel when both; flush refills
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) credit <= CRED_MAX;
    else if (invalidate) credit <= CRED_MAX;
    else if (load && !done) credit <= credit - 1'b1;
    else if (done && !load) credit <= credit + 1'b1;
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(load && credit == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst || invalidate)
    !(done && !load && credit == CRED_MAX));
endmodule

// File: rtl/dispatcher_multi.sv
// dispatcher_multi: takes one operand beat, resolves forwarded operands,
// issues it to every targeted lane and queues it in order for writeback.
// Optional: define DISPATCHER_PERF_CNT_EN for saturating perf counters.
module dispatcher_multi
  import offnariscv_pkg::*;
#(
  parameter int NUM_FU     = 3,
  parameter int NUM_FWD    = 2,
  parameter int CREDITS    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  axis_if.s                 rfex_axis_if,
  axis_if.m                 fu_axis_if [NUM_FU],
  input  logic [NUM_FU-1:0] fu_done,
  axis_if.s                 fwd_axis_if [NUM_FWD],
  axis_if.m                 exwb_axis_if,
  input  logic              invalidate
`ifdef DISPATCHER_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_credit_stall_cnt
`endif
);
  dispatch_tdata_t              rd;
  lane_tdata_t                  lane_in;
  exwb_tdata_t                  push_beat;
  lane_tdata_t [NUM_FU-1:0]     lane_out;
  logic [NUM_FU-1:0]            fu_tgt, slot_free, has_credit, lane_load;
  logic [NUM_FWD-1:0][XLEN-1:0] fwd_data;
  logic [NUM_FWD-1:0]           fwd_vld;
  logic [XLEN-1:0]              op1, op2;
  logic                         op1_ok, op2_ok, lanes_ok, fifo_rdy, accept, rdy, live;

  assign rd     = rfex_axis_if.tdata;
  assign fu_tgt = rd.fu_vld[NUM_FU-1:0];

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
    assign fwd_data[k]           = fwd_axis_if[k].tdata;
    assign fwd_vld[k]            = fwd_axis_if[k].tvalid;
    assign fwd_axis_if[k].tready = 1'b1;
  end

  // Pick RF or forwarded value per operand; a forwarded one must be valid
  always_comb begin
    op1    = rd.op1;
    op2    = rd.op2;
    op1_ok = rd.sel1 == '0;
    op2_ok = rd.sel2 == '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (rd.sel1 == fwd_sel_t'(k + 1)) begin
        op1    = fwd_data[k];
        op1_ok = fwd_vld[k];
      end
      if (rd.sel2 == fwd_sel_t'(k + 1)) begin
        op2    = fwd_data[k];
        op2_ok = fwd_vld[k];
      end
    end
  end

  // Accepting is held off for the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else live <= 1'b1;
  end

  assign lanes_ok  = &(~fu_tgt | (slot_free & has_credit));
  assign rdy       = live && !invalidate && fifo_rdy && lanes_ok && op1_ok && op2_ok;
  assign accept    = rfex_axis_if.tvalid && rdy;
  assign lane_load = fu_tgt & {NUM_FU{accept}};
  assign lane_in   = '{op1: op1, op2: op2, cmd: rd.cmd};
  assign push_beat = '{fu_vld: rd.fu_vld, lane: lane_in};

  assign rfex_axis_if.tready = rdy;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
    dispatch_lane #(.CREDITS(CREDITS)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .invalidate (invalidate),
      .load       (lane_load[i]),
      .load_data  (lane_in),
      .done       (fu_done[i]),
      .tready     (fu_axis_if[i].tready),
      .tvalid     (fu_axis_if[i].tvalid),
      .tdata      (lane_out[i]),
      .slot_free  (slot_free[i]),
      .has_credit (has_credit[i])
    );
    assign fu_axis_if[i].tdata = lane_out[i];
  end

  axis_sync_fifo #(.W($bits(exwb_tdata_t)), .DEPTH(FIFO_DEPTH)) u_wb_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (invalidate),
    .s_tvalid (accept),
    .s_tready (fifo_rdy),
    .s_tdata  (push_beat),
    .m_tvalid (exwb_axis_if.tvalid),
    .m_tready (exwb_axis_if.tready),
    .m_tdata  (exwb_axis_if.tdata)
  );

`ifdef DISPATCHER_PERF_CNT_EN
  logic stall, credit_stall;
  assign stall        = rfex_axis_if.tvalid && !rdy;
  // Stalled only because some targeted lane is out of credit
  assign credit_stall = stall && live && !invalidate && fifo_rdy && op1_ok && op2_ok
                        && &(~fu_tgt | slot_free) && |(fu_tgt & ~has_credit);

  // Saturating event counters, cleared by flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_cnt        <= '0;
      perf_stall_cnt        <= '0;
      perf_credit_stall_cnt <= '0;
    end else if (invalidate) begin
      perf_issue_cnt        <= '0;
      perf_stall_cnt        <= '0;
      perf_credit_stall_cnt <= '0;
    end else begin
      if (accept && perf_issue_cnt != '1) perf_issue_cnt <= perf_issue_cnt + 1'b1;
      if (stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (credit_stall && perf_credit_stall_cnt != '1)
        perf_credit_stall_cnt <= perf_credit_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: doc/dispatcher_multi.md
DISPATCHER_MULTI -- requirements
Module: dispatcher_multi

Interface
REQ-001 SHALL have parameter NUM_FU, default 3, meaning the number of functional-unit issue lanes (1..8).
REQ-002 SHALL have parameter NUM_FWD, default 2, meaning the number of forwarding sources (1..4).
REQ-003 SHALL have parameter CREDITS, default 2, meaning the maximum outstanding beats per lane (1..15).
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, meaning the depth of the writeback FIFO.
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 SHALL have port rfex_axis_if, axis_if.s, dispatch_tdata_t, carrying operands, per-lane command valid vector fu_vld[NUM_FU], and per-operand forwarding selectors.
REQ-008 SHALL have port fu_axis_if[NUM_FU], axis_if.m, lane tdata, carrying per-lane issue.
REQ-009 SHALL have port fu_done, input, NUM_FU bits, carrying per-lane completion pulses that return credits.
REQ-010 SHALL have port fwd_axis_if[NUM_FWD], axis_if.s, XLEN, carrying forwarding sources; tvalid marks the data as usable.
REQ-011 SHALL have port exwb_axis_if, axis_if.m, exwb_tdata_t, carrying the beat to writeback.
REQ-012 SHALL have port invalidate, input, 1 bit, which flushes all state.

Function
REQ-013 Operand selector encoding SHALL be: 0 = register-file value; k in 1..NUM_FWD = fwd_axis_if[k-1].tdata.
REQ-014 rfex_axis_if.tready SHALL be high only when all of the following hold:
- !invalidate;
- the exwb FIFO is not full;
- every lane i with fu_vld[i] has its output slot empty, or draining this cycle, and credit>0;
- every nonzero selector's source tvalid is high.
REQ-015 On accept, each targeted lane's output register SHALL load the forwarded operands and command, so lane tvalid rises the next cycle (1-cycle latency).
REQ-016 A lane's tvalid SHALL hold, with tdata stable, until the lane's tready is high.
REQ-017 On accept, the beat SHALL be pushed into the exwb FIFO in the same cycle, including beats with fu_vld all zero.
REQ-018 Per-lane credit counter rules:
- decrement on accept to that lane;
- increment on fu_done[i];
- both in the same cycle leave it unchanged;
- it SHALL never exceed CREDITS nor underflow (asserted).
REQ-019 The exwb FIFO SHALL preserve order; beats SHALL leave in acceptance order regardless of lane completion order.
REQ-020 The per-lane state machine SHALL have states EMPTY and FULL:
- EMPTY->FULL on load;
- FULL->EMPTY on handshake without a reload;
- FULL->FULL on handshake with a simultaneous reload.
REQ-021 When invalidate is high, on the next edge all lanes SHALL go to EMPTY, credits SHALL return to CREDITS, and the FIFO SHALL empty; fu_done pulses arriving in the same cycle SHALL be ignored.
REQ-022 When invalidate and an rfex beat coincide, the beat SHALL be dropped (tready low).

Reset
REQ-023 While rst is low, all lane tvalid, exwb_axis_if.tvalid and rfex_axis_if.tready SHALL be 0, lanes SHALL be EMPTY, and credits SHALL be CREDITS.
REQ-024 Reset deassertion mid-stream SHALL yield no spurious output; the first accept is possible one cycle after release.

Configuration
REQ-025 With DISPATCHER_PERF_CNT_EN defined, the block SHALL expose 32-bit saturating counters, all reset to 0 and cleared on invalidate:
- perf_issue_cnt: counts accepts;
- perf_stall_cnt: counts cycles with rfex tvalid high and tready low;
- perf_credit_stall_cnt: counts stalls caused solely by zero credit.
REQ-026 Without DISPATCHER_PERF_CNT_EN, those ports and registers SHALL not exist.

Structure
REQ-027 offnariscv_pkg SHALL hold dispatch_tdata_t, lane_tdata_t, fwd_sel_t (width $clog2(NUM_FWD+1)), and the credit-counter width.
REQ-028 One sub-module, dispatch_lane, SHALL contain one output slot, the EMPTY/FULL state, and the credit counter; the existing axis_sync_fifo SHALL be reused for writeback.

Verification
REQ-029 Lane 1 only, sel=0, lane tready=1 -> lane1 tvalid one cycle after accept, op1/op2 equal the RF values, and the exwb beat is identical.
REQ-030 CREDITS=2, fu_done held low, three beats to lane0 -> two accepted; the third stalls until fu_done[0] pulses, then is accepted the next cycle.
REQ-031 sel1=2 with fwd_axis_if[1].tvalid=0 for 3 cycles, tdata=32'hDEADBEEF -> tready low for 3 cycles, then lane op1=32'hDEADBEEF.
REQ-032 Lane tready held low with a new beat pending -> lane tdata stable; the beat is accepted the same cycle tready rises.
REQ-033 invalidate during FULL lanes, a FIFO holding 2 beats, and a coinciding fu_done -> next cycle all tvalid 0, credits=CREDITS, FIFO empty.
REQ-034 rst pulled low mid-transfer -> outputs go to 0 immediately; perf counters read 0 after release.
